imem_boot_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/byte_to_word_packer.sv | 67 ++++++
 rtl/imem_boot_loader.sv | 195 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the instruction-memory boot loader.
//   - INSTR_W        : instruction word width (32)
//   - loader_state_e : boot loader FSM states
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CKSUM  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// ---------------------------------------------------------------------------
// byte_to_word_packer
//   Assembles big-endian 32-bit words from a byte stream. The first byte of
//   each group of four lands in the most significant position.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high; clears byte counter
//   byte_valid_i   in   a byte is consumed this cycle
//   byte_i         in   the byte
//   last_byte_o    out  the next consumed byte completes a word
//   word_valid_o   out  one-cycle pulse, registered, the cycle after the
//                       4th byte of a word is consumed
//   word_o         out  assembled word (held until the next word)
// ---------------------------------------------------------------------------
module byte_to_word_packer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic               last_byte_o,
    output logic               word_valid_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic               word_valid_q, word_valid_d;
    logic [INSTR_W-1:0] word_q, word_d;

    assign last_byte_o  = (cnt_q == 2'd3);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
            if (cnt_q == 2'd3) begin
                // shift_q holds the three earlier bytes, oldest on top
                word_valid_d = 1'b1;
                word_d       = {shift_q, byte_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 2'd0;
            shift_q      <= 24'd0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time loader for the instruction memory. Accepts a byte stream
//   (LEN_HI, LEN_LO, 4*N data bytes MSB-first, optional checksum byte),
//   writes the words from word address 0 upward, and holds the core in
//   reset until the image is complete.
//
//   Optional feature macro: LOADER_CKSUM_EN
//     defined   -> running XOR over data bytes, trailing checksum byte
//                  checked; mismatch rejects the image
//     undefined -> stream ends after the last data byte
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
//   in_ready does not depend on in_valid; without a transfer all state holds.
//
// Ports
//   clk, reset      clock / synchronous active-high reset
//   in_valid        byte available
//   in_byte         stream byte
//   in_ready        loader can accept a byte (combinational state decode)
//   imem_we         instruction-memory write strobe, one cycle per word
//   imem_addr       word address of the write
//   imem_wdata      instruction word
//   load_done       image loaded (sticky until reset)
//   load_err        image rejected (sticky until reset)
//   core_reset      drives the core's reset; falls one cycle after load_done
//   dbg_state_o     current FSM state, for observation only
// ---------------------------------------------------------------------------
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               load_done,
    output logic               load_err,
    output logic               core_reset,
    output loader_state_e      dbg_state_o
);

    // Largest legal word count, widened so that 2**16 can never overflow
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

`ifdef LOADER_CKSUM_EN
    localparam loader_state_e AFTER_DATA = S_CKSUM;
`else
    localparam loader_state_e AFTER_DATA = S_DONE;
`endif

    loader_state_e      state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [15:0]        n_q, n_d;
    logic [ADDR_W:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, err_q, core_reset_q;
`ifdef LOADER_CKSUM_EN
    logic [7:0]         cksum_q, cksum_d;
`endif

    logic               xfer;
    logic               data_xfer;
    logic [15:0]        len_n;
    logic [ADDR_W:0]    idx_inc;
    logic               last_byte;
    logic               word_valid;
    logic [INSTR_W-1:0] word;

    always_comb begin
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CKSUM: in_ready = 1'b1;
            default:                             in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid && in_ready;
    assign data_xfer = xfer && (state_q == S_DATA);
    assign len_n     = {len_hi_q, in_byte};
    assign idx_inc   = idx_q + 1'b1;

    byte_to_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (data_xfer),
        .byte_i       (in_byte),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
`ifdef LOADER_CKSUM_EN
        cksum_d  = cksum_q;
`endif
        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    n_d = len_n;
                    if ({1'b0, len_n} > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_n == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ in_byte;
`endif
                    if (last_byte) begin
                        // Address is latched with the word so both appear
                        // together on the registered write port next cycle.
                        addr_d = idx_q[ADDR_W-1:0];
                        idx_d  = idx_inc;
                        if (17'(idx_inc) == {1'b0, n_q}) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                if (xfer) begin
                    state_d = (in_byte == cksum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LEN_HI;
            len_hi_q     <= 8'd0;
            n_q          <= 16'd0;
            idx_q        <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_reset_q <= 1'b1;
`ifdef LOADER_CKSUM_EN
            cksum_q      <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            done_q       <= (state_d == S_DONE);
            err_q        <= (state_d == S_ERR);
            // Trails load_done by one cycle so the final write commits
            // before the core starts fetching.
            core_reset_q <= !done_q;
`ifdef LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign imem_we     = word_valid;
    assign imem_addr   = addr_q;
    assign imem_wdata  = word;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign core_reset  = core_reset_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader. A reference model turns a list
//   of words into the byte stream plus the expected writes and outcome; a
//   negedge monitor checks every write against the expected queue.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [31:0]        imem_wdata;
    logic               load_done;
    logic               load_err;
    logic               core_reset;
    loader_state_e      dbg_state;

    int tests = 0;
    int fails = 0;

    logic [31:0]       img_q[$];
    logic [7:0]        stream_q[$];
    bit                end_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    bit                exp_done;
    bit                pending_we = 1'b0;
    bit                prev_we    = 1'b0;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .load_done   (load_done),
        .load_err    (load_err),
        .core_reset  (core_reset),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        pending_we = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_load_done",  32'(load_done),  32'd0);
        check("rst_load_err",   32'(load_err),   32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_state",      32'(dbg_state),  32'(S_LEN_HI));
    endtask

    // ---------------- reference model ----------------
    // Builds the byte stream for a word count n using img_q as the payload,
    // and queues the writes and outcome the loader must produce.
    task automatic build_image(input int n, input bit bad_cksum);
        logic [7:0] x;
        logic [7:0] b;
        stream_q.delete();
        end_q.delete();
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        end_q.push_back(1'b0);
        end_q.push_back(1'b0);
        x = 8'h00;
        if (n > CAP) begin
            exp_done = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(img_q[i] >> (24 - 8 * k));
                stream_q.push_back(b);
                end_q.push_back(k == 3);
                x = x ^ b;
            end
            exp_addr_q.push_back(ADDR_W'(i % CAP));
            exp_data_q.push_back(img_q[i]);
        end
`ifdef LOADER_CKSUM_EN
        stream_q.push_back(bad_cksum ? (x ^ 8'h01) : x);
        end_q.push_back(1'b0);
        exp_done = !bad_cksum;
`else
        exp_done = 1'b1;
        if (bad_cksum) exp_done = 1'b1;
`endif
    endtask

    task automatic random_image(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input bit is_end, input int gap);
        loader_state_e st;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            st       = dbg_state;
            @(negedge clk);
            check("idle_state_hold", 32'(dbg_state), 32'(st));
        end
        in_valid = 1'b1;
        in_byte  = b;
        check("ready_before_xfer", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (is_end) pending_we = 1'b1;
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle before every byte, 2 random
    task automatic play(input int upto, input int gap_mode);
        int gap;
        for (int p = 0; p < upto; p++) begin
            if (gap_mode == 0)      gap = 0;
            else if (gap_mode == 1) gap = 1;
            else                    gap = ($urandom_range(0, 2) == 0) ? 1 : 0;
            send_byte(stream_q[p], end_q[p], gap);
        end
    endtask

    // Called right after the final transfer edge (cycle t ends).
    task automatic check_end();
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_done) begin
            check("done_t1",       32'(load_done),  32'd1);
            check("err_t1",        32'(load_err),   32'd0);
            check("core_reset_t1", 32'(core_reset), 32'd1);
            check("state_done",    32'(dbg_state),  32'(S_DONE));
            @(negedge clk);
            check("core_reset_t2", 32'(core_reset), 32'd0);
        end else begin
            check("err_t1",        32'(load_err),   32'd1);
            check("done_t1",       32'(load_done),  32'd0);
            check("state_err",     32'(dbg_state),  32'(S_ERR));
            @(negedge clk);
            check("core_reset_t2", 32'(core_reset), 32'd1);
        end
        check("ready_after_end", 32'(in_ready), 32'd0);
        // Extra bytes after the end must be ignored.
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("writes_drained", 32'(exp_addr_q.size()), 32'd0);
        check("done_sticky",    32'(load_done),  32'(exp_done));
        check("err_sticky",     32'(load_err),   32'(!exp_done));
        check("core_reset_end", 32'(core_reset), 32'(!exp_done));
    endtask

    // ---------------- write monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && (imem_we || pending_we)) begin
            check("we_timing", 32'(imem_we), 32'(pending_we));
            if (imem_we) begin
                check("we_not_back_to_back", 32'(prev_we), 32'd0);
                check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
                    check("write_data", imem_wdata, exp_data_q.pop_front());
                end
            end
        end
        pending_we = 1'b0;
        prev_we    = imem_we;
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        // Two-word image, back-to-back
        apply_reset();
        img_q = '{32'h2008_0005, 32'hAC08_0000};
        build_image(2, 1'b0);
        play(stream_q.size(), 0);
        check_end();

        // Same image, valid toggling every other cycle
        apply_reset();
        img_q = '{32'h2008_0005, 32'hAC08_0000};
        build_image(2, 1'b0);
        play(stream_q.size(), 1);
        check_end();

        // Oversized word count: rejected right after LEN_LO
        apply_reset();
        build_image(32'h0101, 1'b0);
        play(2, 0);
        check_end();

        // Random oversized word count
        apply_reset();
        build_image($urandom_range(CAP + 1, 65535), 1'b0);
        play(2, 2);
        check_end();

        // Exactly full memory
        apply_reset();
        random_image(CAP);
        build_image(CAP, 1'b0);
        play(stream_q.size(), 2);
        check_end();

        // Empty image
        apply_reset();
        img_q.delete();
        build_image(0, 1'b0);
        play(stream_q.size(), 0);
        check_end();

        // Reset after 5 data bytes, then a fresh one-word image
        apply_reset();
        random_image(2);
        build_image(2, 1'b0);
        play(7, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state",     32'(dbg_state),  32'(S_LEN_HI));
        check("midrst_in_ready",  32'(in_ready),   32'd1);
        check("midrst_core_rst",  32'(core_reset), 32'd1);
        check("midrst_first_wr",  32'(exp_addr_q.size()), 32'd1);
        exp_addr_q.delete();
        exp_data_q.delete();
        random_image(1);
        build_image(1, 1'b0);
        play(stream_q.size(), 0);
        check_end();

        // Random small images with random gaps
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            random_image($urandom_range(1, 9));
            build_image(img_q.size(), 1'b0);
            play(stream_q.size(), 2);
            check_end();
        end

`ifdef LOADER_CKSUM_EN
        // Checksum accepted: 01^02^04^08 = 0F
        apply_reset();
        img_q = '{32'h0102_0408};
        build_image(1, 1'b0);
        check("cksum_good_byte", 32'(stream_q[6]), 32'h0F);
        play(stream_q.size(), 0);
        check_end();

        // Checksum 0E rejected
        apply_reset();
        img_q = '{32'h0102_0408};
        build_image(1, 1'b1);
        check("cksum_bad_byte", 32'(stream_q[6]), 32'h0E);
        play(stream_q.size(), 1);
        check_end();
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
